// File: rtl/mux_pkg.sv
// Shared constants for mux_n_1_reg: default sizes, mode encodings, output-register states.
// Mode encodings are only consumed when MUX_N_1_RR_EN is defined.
package mux_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_CHANNELS = 4;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/mux_n_1_reg_rr_pick.sv
// rr_pick: first valid channel strictly after ptr_i, searching cyclically.
// any_o is low when no channel is valid (grant_o is then 0). Used only with MUX_N_1_RR_EN.
module rr_pick
  import mux_pkg::*;
#(
  parameter  int unsigned CHANNELS = DEF_CHANNELS,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] valid_i,
  input  logic [SEL_W-1:0]    ptr_i,
  output logic [SEL_W-1:0]    grant_o,
  output logic                any_o
);

  logic [SEL_W-1:0] idx;

  // Walk from the farthest offset back to the nearest so the nearest valid wins.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    idx     = '0;
    for (int unsigned k = CHANNELS; k >= 1; k--) begin
      idx = SEL_W'((32'(ptr_i) + k) % CHANNELS);
      if (valid_i[idx]) begin
        grant_o = idx;
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_n_1_reg.sv
// N:1 registered mux with valid/ready handshake and a single-entry output register.
// Define MUX_N_1_RR_EN to add the 'mode' port and a round-robin grant (rr_pick).
module mux_n_1_reg
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH    = DEF_WIDTH,
  parameter  int unsigned CHANNELS = DEF_CHANNELS,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] i,
  input  logic [CHANNELS-1:0]       i_valid,
  output logic [CHANNELS-1:0]       i_ready,
  input  logic [SEL_W-1:0]          s,
`ifdef MUX_N_1_RR_EN
  input  logic                      mode,
`endif
  output logic [WIDTH-1:0]          z,
  output logic                      z_valid,
  input  logic                      z_ready,
  output logic [SEL_W-1:0]          z_ch
);

  out_state_e       state_q;
  logic [WIDTH-1:0] z_q;
  logic [SEL_W-1:0] z_ch_q;
  logic [SEL_W-1:0] grant;
  logic             grant_ok;
  logic             grant_valid;
  logic [WIDTH-1:0] sel_data;
  logic             can_load;
  logic             xfer;

`ifdef MUX_N_1_RR_EN
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_any;

  rr_pick #(.CHANNELS(CHANNELS)) u_rr_pick (
    .valid_i (i_valid),
    .ptr_i   (ptr_q),
    .grant_o (rr_grant),
    .any_o   (rr_any)
  );

  assign grant    = (mode == MODE_RR) ? rr_grant : s;
  assign grant_ok = (mode == MODE_RR) ? rr_any : 1'b1;
`else
  assign grant    = s;
  assign grant_ok = 1'b1;
`endif

  // A select beyond CHANNELS-1 matches no channel, so it never transfers.
  always_comb begin
    grant_valid = 1'b0;
    sel_data    = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (grant == SEL_W'(k)) begin
        grant_valid = i_valid[k];
        sel_data    = i[k*WIDTH +: WIDTH];
      end
    end
  end

  assign z_valid  = (state_q == FULL);
  assign can_load = !z_valid || z_ready;
  assign xfer     = rst_n && can_load && grant_ok && grant_valid;

  always_comb begin
    i_ready = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      i_ready[k] = xfer && (grant == SEL_W'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      z_q     <= '0;
      z_ch_q  <= '0;
`ifdef MUX_N_1_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      if (xfer) begin
        z_q    <= sel_data;
        z_ch_q <= grant;
      end
      case (state_q)
        EMPTY:   if (xfer) state_q <= FULL;
        FULL:    if (!xfer && z_ready) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
`ifdef MUX_N_1_RR_EN
      // Pointer tracks round-robin grants only; manual transfers leave it alone.
      if (xfer && (mode == MODE_RR)) ptr_q <= grant;
`endif
    end
  end

  assign z    = z_q;
  assign z_ch = z_ch_q;

endmodule

// File: tb/tb_mux_n_1_reg.sv
// Self-checking bench for mux_n_1_reg (4-channel main instance plus a 3-channel instance).
// Round-robin scenarios are compiled in when MUX_N_1_RR_EN is defined.
`timescale 1ns/1ps
module tb_mux_n_1_reg;
  import mux_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned CH = 4;
  localparam int unsigned SW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CH*W-1:0] i;
  logic [CH-1:0]   i_valid, i_ready;
  logic [SW-1:0]   s, z_ch;
  logic            mode;
  logic [W-1:0]    z;
  logic            z_valid, z_ready;

  logic [23:0] i3;
  logic [2:0]  v3, r3;
  logic [1:0]  s3, zch3;
  logic [7:0]  z3;
  logic        zv3, zr3;

  mux_n_1_reg #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst_n(rst_n), .i(i), .i_valid(i_valid), .i_ready(i_ready), .s(s),
`ifdef MUX_N_1_RR_EN
    .mode(mode),
`endif
    .z(z), .z_valid(z_valid), .z_ready(z_ready), .z_ch(z_ch)
  );

  mux_n_1_reg #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .i(i3), .i_valid(v3), .i_ready(r3), .s(s3),
`ifdef MUX_N_1_RR_EN
    .mode(MODE_MANUAL),
`endif
    .z(z3), .z_valid(zv3), .z_ready(zr3), .z_ch(zch3)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one-entry output register, grant rule evaluated from scratch each cycle.
  logic         m_valid = 1'b0;
  logic [W-1:0] m_z     = '0;
  logic [SW-1:0] m_ch   = '0;
  int           m_ptr   = 0;

  function automatic int m_grant();
    if (mode) begin
      for (int k = 1; k <= CH; k++) begin
        int c;
        c = (m_ptr + k) % CH;
        if (i_valid[c]) return c;
      end
      return -1;
    end
    return int'(s);
  endfunction

  function automatic int m_take();
    int g;
    g = m_grant();
    if (!rst_n || g < 0 || g >= CH) return -1;
    if (!i_valid[g]) return -1;
    if (m_valid && !z_ready) return -1;
    return g;
  endfunction

  function automatic logic [CH-1:0] m_ready();
    int g;
    g = m_take();
    m_ready = '0;
    if (g >= 0) m_ready[g] = 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int g;
    if (!rst_n) begin
      m_valid = 1'b0; m_z = '0; m_ch = '0; m_ptr = 0;
    end else begin
      g = m_take();
      if (g >= 0) begin
        m_valid = 1'b1;
        m_z     = i[g*W +: W];
        m_ch    = SW'(g);
        if (mode) m_ptr = g;
      end else if (z_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_z_valid", 32'(z_valid), 32'(m_valid));
    chk("cmp_z_ch",    32'(z_ch),    32'(m_ch));
    chk("cmp_z",       32'(z),       32'(m_z));
    chk("cmp_i_ready", 32'(i_ready), 32'(m_ready()));
  end

  logic [7:0] seq_exp [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
  logic [1:0] rr_exp  [5] = '{2'd1, 2'd3, 2'd0, 2'd1, 2'd3};

  initial begin
    i = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    i_valid = 4'hF; s = '0; mode = MODE_MANUAL; z_ready = 1'b1;
    i3 = {8'h33, 8'h22, 8'h11}; v3 = '0; s3 = '0; zr3 = 1'b1;

    repeat (2) tick();
    chk("rst_z",       32'(z), 0);
    chk("rst_z_valid", 32'(z_valid), 0);
    chk("rst_z_ch",    32'(z_ch), 0);
    chk("rst_i_ready", 32'(i_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 4; k++) begin
      s = SW'(k);
      tick();
      chk("seq_z",       32'(z), 32'(seq_exp[k]));
      chk("seq_z_ch",    32'(z_ch), k);
      chk("seq_z_valid", 32'(z_valid), 1);
    end

    s = 2'd1;
    tick();
    chk("stall_load_z", 32'(z), 32'h B1);
    z_ready = 1'b0;
    tick();
    chk("stall_hold_z", 32'(z), 32'hB1);
    chk("stall_ready",  32'(i_ready), 0);
    i[15:8] = 8'd55; s = 2'd2;
    tick();
    chk("stall_hold2_z",  32'(z), 32'hB1);
    chk("stall_hold2_ch", 32'(z_ch), 1);
    z_ready = 1'b1; s = 2'd1;
    tick();
    chk("stall_release_z", 32'(z), 32'd55);

    s = 2'd0;
    for (int k = 0; k < 6; k++) begin
      i[7:0] = 8'(8'h10 + k);
      tick();
      chk("stream_z",       32'(z), 32'(8'h10 + k));
      chk("stream_z_valid", 32'(z_valid), 1);
    end

    i_valid = 4'h0;
    tick();
    chk("drain_z_valid", 32'(z_valid), 0);
    i_valid = 4'b1011; s = 2'd2;
    tick();
    chk("invalid_grant_empty", 32'(z_valid), 0);
    s = 2'd0;
    tick();
    chk("load_ch0", 32'(z), 32'h15);
    s = 2'd2;
    tick();
    chk("invalid_grant_drain", 32'(z_valid), 0);

    i_valid = 4'hF; s = 2'd3;
    tick();
    chk("pre_reset_z", 32'(z), 32'hD3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_z",       32'(z), 0);
    chk("async_rst_z_valid", 32'(z_valid), 0);
    chk("async_rst_z_ch",    32'(z_ch), 0);
    chk("async_rst_ready",   32'(i_ready), 0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_z", 32'(z), 32'hD3);

`ifdef MUX_N_1_RR_EN
    i_valid = 4'b1011; mode = MODE_RR; z_ready = 1'b1; s = 2'd2;
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_seq_ch", 32'(z_ch), 32'(rr_exp[k]));
      chk("rr_seq_valid", 32'(z_valid), 1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rr_rst_z_valid", 32'(z_valid), 0);
    chk("rr_rst_z_ch",    32'(z_ch), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rr_first_after_rst", 32'(z_ch), 1);
    mode = MODE_MANUAL;
`endif

    s3 = 2'd3; v3 = 3'b111;
    tick();
    chk("ch3_oob_ready", 32'(r3), 0);
    tick();
    chk("ch3_oob_valid", 32'(zv3), 0);
    s3 = 2'd2;
    #1;
    chk("ch3_ready2", 32'(r3), 32'b100);
    tick();
    chk("ch3_z",    32'(z3), 32'h33);
    chk("ch3_z_ch", 32'(zch3), 2);

    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_n_1_reg.md
MUX_N_1_REG -- requirements
Module: mux_n_1_reg

Interface
REQ-001 Parameter WIDTH, default 8, data bits per channel (>=1).
REQ-002 Parameter CHANNELS, default 4, number of input channels (>=2).
REQ-003 Localparam SEL_W = $clog2(CHANNELS), the select and channel-index width.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 i  input  CHANNELS*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 i_valid  input  CHANNELS  per-channel data-valid.
REQ-008 i_ready  output  CHANNELS  per-channel accept strobe.
REQ-009 s  input  SEL_W  manual channel select.
REQ-010 z  output  WIDTH  registered selected data.
REQ-011 z_valid  output  1  z holds unconsumed data.
REQ-012 z_ready  input  1  downstream accepts z.
REQ-013 z_ch  output  SEL_W  index of the channel that supplied z.

Function
REQ-014 The output register SHALL be one entry with two states: EMPTY (z_valid=0) and FULL (z_valid=1).
REQ-015 can_load SHALL equal !z_valid | z_ready.
REQ-016 Exactly one channel (the grant) SHALL be considered per cycle; i_ready[g]=can_load & i_valid[g] & grant_ok, and all other i_ready bits SHALL be 0.
REQ-017 A transfer on channel g SHALL load z<=i[g] and z_ch<=g, and SHALL set z_valid=1 on the next edge; latency is 1 cycle.
REQ-018 EMPTY->FULL on a transfer; FULL->EMPTY on z_ready with no transfer; FULL->FULL on a simultaneous drain and load, sustaining 1 word/cycle.
REQ-019 While FULL and z_ready=0, z and z_ch SHALL hold stable regardless of i, i_valid and s.
REQ-020 In manual mode grant=s; if s>=CHANNELS, grant_ok=0, no transfer occurs and all i_ready bits are 0.
REQ-021 An invalid granted channel SHALL cause no transfer; state is unchanged apart from any drain.

Reset
REQ-022 On rst_n=0, z, z_ch and z_valid SHALL clear to 0 immediately, regardless of clk; the round-robin pointer SHALL also clear to 0 when present.
REQ-023 Reset mid-transfer SHALL discard the held word; the first grant after release follows the reset pointer.
REQ-024 i_ready SHALL be 0 throughout reset.

Configuration
REQ-025 Macro MUX_N_1_RR_EN, when defined, SHALL add input port mode (1 bit, placed after s): mode=0 selects manual; mode=1 selects round-robin.
REQ-026 In round-robin mode grant SHALL be the first valid channel strictly after the pointer, searching cyclically and wrapping from CHANNELS-1 to 0; s is ignored.
REQ-027 The pointer SHALL update to the granted index only on a transfer; with no valid channel, no transfer occurs.
REQ-028 Without MUX_N_1_RR_EN, the mode port and pointer SHALL be absent and behaviour SHALL be manual only.

Structure
REQ-029 Package mux_pkg SHALL hold the default WIDTH/CHANNELS constants and the mode encodings MODE_MANUAL=1'b0 and MODE_RR=1'b1.
REQ-030 Round-robin selection SHALL be a sub-module rr_pick (inputs: valid vector and pointer; outputs: grant index and any-valid), instantiated only under MUX_N_1_RR_EN.

Verification (CHANNELS=4, WIDTH=8 unless stated)
REQ-031 i={D3,C2,B1,A0}, i_valid=4'hF, z_ready=1, s stepped 0..3 -> one cycle later z=A0,B1,C2,D3 in turn, with z_ch=s and z_valid=1.
REQ-032 s=1, z_ready=0 -> z=B1 held with i_ready=0; i[1] changed to 55 -> z stays B1; z_ready=1 -> next cycle z=55.
REQ-033 CHANNELS=3, s=3, i_valid=3'b111 -> i_ready=0 and z_valid stays 0.
REQ-034 MUX_N_1_RR_EN, mode=1, i_valid=4'b1011, z_ready=1 -> z_ch sequence 1,3,0,1,3 (the pointer starts at 0).
REQ-035 Full pipe, z_ready=1, new data every cycle -> z_valid stays 1 and one word is delivered per cycle with no bubble.
REQ-036 rst_n pulsed low mid-stream with z_valid=1 and no clk edge -> z, z_ch and z_valid are 0 immediately; in RR mode the first grant after release is channel 1.
